// File: rtl/vga_pkg.sv
// Shared VGA / frame-buffer definitions: screen geometry, VRAM sizing and
// the arbiter state encoding used by vram_arbiter.
package vga_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 360;
  localparam int VRAM_DEPTH    = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int VRAM_A_WIDTH  = 18;
  localparam int VRAM_D_WIDTH  = 6;

  // IDLE: port free, RD: read address on port, CAP: read data returning,
  // WR: write on port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_addr_gen.sv
// vram_addr_gen: owns the registered VRAM port address. Loads the scan-out
// address y*SCREEN_WIDTH + x on a read decision, the requester address on a
// write decision, and otherwise holds.
module vram_addr_gen import vga_pkg::*; #(
  parameter int ADDR_WIDTH   = vga_pkg::VRAM_A_WIDTH,
  parameter int SCREEN_WIDTH = vga_pkg::SCREEN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ld_rd,
  input  logic                  i_ld_wr,
  input  logic [9:0]            i_x,
  input  logic [8:0]            i_y,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pix_addr;

  // Full-width product so in-range coordinates never truncate
  assign pix_addr = ADDR_WIDTH'(i_y) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(i_x);

  // Select next port address: scan-out read, write, or hold
  always_comb begin
    addr_d = addr_q;
    if (i_ld_rd) begin
      addr_d = pix_addr;
    end else if (i_ld_wr) begin
      addr_d = i_wr_addr;
    end
  end

  // Address register, cleared on reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign o_addr = addr_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port registered-output VRAM between VGA
// scan-out (absolute priority, one port cycle per active pixel) and a single
// write requester that uses the remaining cycles.
// Optional build macro VRAM_ARB_VBLANK_ONLY_EN: when defined, writes are only
// granted while i_y >= SCREEN_HEIGHT (vertical blanking).
module vram_arbiter import vga_pkg::*; #(
  parameter int ADDR_WIDTH    = vga_pkg::VRAM_A_WIDTH,
  parameter int DATA_WIDTH    = vga_pkg::VRAM_D_WIDTH,
  parameter int SCREEN_WIDTH  = vga_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = vga_pkg::SCREEN_HEIGHT,
  parameter int VRAM_DEPTH    = SCREEN_WIDTH * SCREEN_HEIGHT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pix_stb,
  input  logic [9:0]            i_x,
  input  logic [8:0]            i_y,
  input  logic                  i_active,
  output logic [DATA_WIDTH-1:0] o_pix_data,
  output logic                  o_pix_valid,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_gnt,
  output logic                  o_wr_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(VRAM_DEPTH);
  localparam logic [8:0]          BLANK_Y   = 9'(SCREEN_HEIGHT);

  arb_state_e            state_q, state_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  wr_gnt_q, wr_gnt_d;
  logic                  wr_err_q, wr_err_d;
  logic                  ld_rd, ld_wr;
  logic                  wr_in_range;
  logic                  wr_window;

  assign wr_in_range = {1'b0, i_wr_addr} < DEPTH_EXT;

`ifdef VRAM_ARB_VBLANK_ONLY_EN
  // Tear-free mode: the requester only gets the port during vertical blanking
  assign wr_window = (i_y >= BLANK_Y);
`else
  assign wr_window = 1'b1;
`endif

  vram_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .SCREEN_WIDTH (SCREEN_WIDTH)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ld_rd   (ld_rd),
    .i_ld_wr   (ld_wr),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_wr_addr (i_wr_addr),
    .o_addr    (o_mem_addr)
  );

  // Per-cycle port decision: RD always runs into CAP, otherwise an active
  // strobe wins over a pending write; CAP captures the sram output
  always_comb begin
    state_d     = state_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    mem_write_d = 1'b0;
    mem_data_d  = mem_data_q;
    wr_gnt_d    = 1'b0;
    wr_err_d    = 1'b0;
    ld_rd       = 1'b0;
    ld_wr       = 1'b0;

    if (state_q == CAP) begin
      pix_data_d  = i_mem_data;
      pix_valid_d = 1'b1;
    end

    if (state_q == RD) begin
      state_d = CAP;
    end else if (i_pix_stb && i_active) begin
      state_d = RD;
      ld_rd   = 1'b1;
    end else if (i_wr_req && wr_window) begin
      state_d     = WR;
      ld_wr       = 1'b1;
      mem_data_d  = i_wr_data;
      mem_write_d = wr_in_range;
      wr_gnt_d    = 1'b1;
      wr_err_d    = !wr_in_range;
    end else begin
      state_d = IDLE;
    end
  end

  // State and output registers; reset clears all outputs and drops any
  // in-flight read
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      mem_write_q <= 1'b0;
      mem_data_q  <= '0;
      wr_gnt_q    <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      mem_write_q <= mem_write_d;
      mem_data_q  <= mem_data_d;
      wr_gnt_q    <= wr_gnt_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign o_pix_valid = pix_valid_q;
  assign o_pix_data  = pix_data_q;
  assign o_mem_write = mem_write_q;
  assign o_mem_data  = mem_data_q;
  assign o_wr_gnt    = wr_gnt_q;
  assign o_wr_err    = wr_err_q;

endmodule
